// File: rtl/wb_j1_pkg.sv
// Shared state encoding and constants for the J1 / Wishbone arbiter.
package wb_j1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBUS = 2'd1,
    IBUS = 2'd2
  } wb_j1_state_e;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Returned on wb_err or timeout; sliced to DATA_W at the point of use.
  localparam int                    MAX_DATA_W = 64;
  localparam logic [MAX_DATA_W-1:0] ERR_DATA   = '1;

endpackage

// File: rtl/wb_j1_watchdog.sv
// Access watchdog for wb_j1_arbiter: counts busy cycles and flags LIMIT reached.
// Only built when WB_J1_TIMEOUT_EN is defined.
`ifdef WB_J1_TIMEOUT_EN
module wb_j1_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  assign expired = (count == 16'(LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/wb_j1_arbiter.sv
// J1 ibus/dbus to single Wishbone classic master bridge with data-first arbitration.
// Optional access watchdog enabled by defining WB_J1_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no Wishbone cycle; picks data request first, then fetch
// DBUS  | Wishbone cycle on behalf of the data bus
// IBUS  | Wishbone cycle on behalf of the instruction fetch
module wb_j1_arbiter
  import wb_j1_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ibus_adr,
  input  logic              ibus_re,
  output logic [DATA_W-1:0] ibus_dat,
  output logic              ibus_ack,
  input  logic [ADDR_W-1:0] dbus_adr,
  input  logic              dbus_re,
  input  logic              dbus_we,
  input  logic [DATA_W-1:0] dbus_s_dat_i,
  output logic [DATA_W-1:0] dbus_s_dat_o,
  output logic              dbus_ack,
  output logic              stall,
  output logic              bus_err,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_m_dat_o,
  input  logic [DATA_W-1:0] wb_m_dat_i,
  output logic              wb_we,
  output logic              wb_stb,
  output logic              wb_cyc,
  input  logic              wb_ack,
  input  logic              wb_err
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DBUS = DBUS;
  localparam logic [1:0] ST_IBUS = IBUS;

  logic [1:0]        state;
  logic              i_done, d_done;
  logic              i_req, d_req;
  logic              busy, term, term_err, timeout_hit;
  logic [DATA_W-1:0] rd_val;

  assign d_req    = (dbus_re | dbus_we) & ~d_done;
  assign i_req    = ibus_re & ~i_done;
  assign stall    = d_req | i_req;
  assign busy     = (state == ST_DBUS) || (state == ST_IBUS);
  assign term_err = busy & (wb_err | timeout_hit);
  assign term     = busy & (wb_ack | wb_err | timeout_hit);
  assign rd_val   = term_err ? ERR_DATA[DATA_W-1:0] : wb_m_dat_i;
  assign wb_cyc   = wb_stb;

`ifdef WB_J1_TIMEOUT_EN
  wb_j1_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~busy),
    .enable  (busy),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = busy & (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      ibus_ack     <= 1'b0;
      dbus_ack     <= 1'b0;
      bus_err      <= 1'b0;
      wb_stb       <= 1'b0;
      wb_we        <= 1'b0;
      wb_adr       <= '0;
      wb_m_dat_o   <= '0;
      ibus_dat     <= '0;
      dbus_s_dat_o <= '0;
    end else begin
      ibus_ack <= 1'b0;
      dbus_ack <= 1'b0;
      bus_err  <= 1'b0;
      // A J1 instruction retires whenever stall is low; arm for the next one.
      if (!stall) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (d_req) begin
            state      <= ST_DBUS;
            wb_adr     <= dbus_adr;
            wb_we      <= dbus_we;
            wb_m_dat_o <= dbus_s_dat_i;
            wb_stb     <= 1'b1;
          end else if (i_req) begin
            state  <= ST_IBUS;
            wb_adr <= ibus_adr;
            wb_we  <= 1'b0;
            wb_stb <= 1'b1;
          end
        end
        ST_DBUS, ST_IBUS: begin
          if (term) begin
            state   <= ST_IDLE;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            bus_err <= term_err;
            if (state == ST_DBUS) begin
              dbus_ack <= 1'b1;
              d_done   <= 1'b1;
              if (!wb_we) dbus_s_dat_o <= rd_val;
            end else begin
              ibus_ack <= 1'b1;
              i_done   <= 1'b1;
              ibus_dat <= rd_val;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          wb_stb <= 1'b0;
          wb_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_j1_arbiter.sv
// Self-checking bench for wb_j1_arbiter: per-instruction cycle schedule model plus random traffic.
`timescale 1ns/1ps
module tb_wb_j1_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ibus_adr = '0;
  logic          ibus_re = 1'b0;
  logic [DW-1:0] ibus_dat;
  logic          ibus_ack;
  logic [AW-1:0] dbus_adr = '0;
  logic          dbus_re = 1'b0;
  logic          dbus_we = 1'b0;
  logic [DW-1:0] dbus_s_dat_i = '0;
  logic [DW-1:0] dbus_s_dat_o;
  logic          dbus_ack;
  logic          stall;
  logic          bus_err;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_m_dat_o;
  logic [DW-1:0] wb_m_dat_i = '0;
  logic          wb_we, wb_stb, wb_cyc;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;

  wb_j1_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_adr(ibus_adr), .ibus_re(ibus_re), .ibus_dat(ibus_dat), .ibus_ack(ibus_ack),
    .dbus_adr(dbus_adr), .dbus_re(dbus_re), .dbus_we(dbus_we),
    .dbus_s_dat_i(dbus_s_dat_i), .dbus_s_dat_o(dbus_s_dat_o), .dbus_ack(dbus_ack),
    .stall(stall), .bus_err(bus_err),
    .wb_adr(wb_adr), .wb_m_dat_o(wb_m_dat_o), .wb_m_dat_i(wb_m_dat_i),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stb;
    logic [15:0] adr;
    logic        we;
    logic [15:0] mdat;
    logic        iack, dack, berr, stall;
    logic [15:0] idat, ddat;
  } exp_t;

  exp_t        e_cur;
  bit          exp_valid = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] cur_i = '0;
  logic [15:0] cur_d = '0;
  int          cur_c, i_ack_at, d_ack_at, stb_cnt, berr_cnt, stall_cnt;
  bit          seen_stb;
  logic [15:0] first_adr;
  logic        first_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid && rst_n) begin
      chk("wb_stb", 32'(wb_stb), 32'(e_cur.stb));
      chk("wb_cyc", 32'(wb_cyc), 32'(e_cur.stb));
      chk("ibus_ack", 32'(ibus_ack), 32'(e_cur.iack));
      chk("dbus_ack", 32'(dbus_ack), 32'(e_cur.dack));
      chk("bus_err", 32'(bus_err), 32'(e_cur.berr));
      chk("stall", 32'(stall), 32'(e_cur.stall));
      chk("ibus_dat", 32'(ibus_dat), 32'(e_cur.idat));
      chk("dbus_s_dat_o", 32'(dbus_s_dat_o), 32'(e_cur.ddat));
      if (e_cur.stb) begin
        chk("wb_adr", 32'(wb_adr), 32'(e_cur.adr));
        chk("wb_we", 32'(wb_we), 32'(e_cur.we));
        if (e_cur.we) chk("wb_m_dat_o", 32'(wb_m_dat_o), 32'(e_cur.mdat));
      end
      if (ibus_ack) i_ack_at = cur_c;
      if (dbus_ack) d_ack_at = cur_c;
      if (wb_stb) stb_cnt++;
      if (bus_err) berr_cnt++;
      if (stall) stall_cnt++;
      if (wb_stb && !seen_stb) begin
        seen_stb  = 1'b1;
        first_adr = wb_adr;
        first_we  = wb_we;
      end
    end
  end

  task automatic clr_mon();
    i_ack_at = -1; d_ack_at = -1; stb_cnt = 0; berr_cnt = 0; stall_cnt = 0; seen_stb = 1'b0;
  endtask

  // One J1 instruction. Outcomes: 0 ack, 1 err, 2 ack+err, 3 no response (timeout).
  // Data access (if any) goes first; the fetch request follows in the data ack cycle.
  task automatic run_instr(input bit has_i, input bit has_d, input bit d_we,
                           input int kd, input int ki, input int od, input int oi,
                           input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                           input logic [15:0] rv_d, input logic [15:0] rv_i);
    exp_t        s[$];
    logic        av[$];
    logic        ev[$];
    logic [15:0] rd[$];
    exp_t        r;
    int          len, t, tc;
    logic [15:0] nd, ni;
    len = 0;
    if (has_d) len += 2 + kd;
    if (has_i) len += 2 + ki;
    for (int c = 0; c <= len; c++) begin
      r.stb = 1'b0; r.adr = '0; r.we = 1'b0; r.mdat = '0;
      r.iack = 1'b0; r.dack = 1'b0; r.berr = 1'b0; r.stall = (c < len);
      r.idat = '0; r.ddat = '0;
      s.push_back(r); av.push_back(1'b0); ev.push_back(1'b0); rd.push_back(16'($urandom));
    end
    t = 0; nd = cur_d; ni = cur_i;
    if (has_d) begin
      for (int c = t + 1; c <= t + 1 + kd; c++) begin
        s[c].stb = 1'b1; s[c].adr = da; s[c].we = d_we; s[c].mdat = wd;
      end
      tc = t + 1 + kd;
      av[tc] = (od == 0 || od == 2); ev[tc] = (od == 1 || od == 2); rd[tc] = rv_d;
      s[tc+1].dack = 1'b1; s[tc+1].berr = (od != 0);
      if (!d_we) nd = (od == 0) ? rv_d : 16'hFFFF;
      t = tc + 1;
    end
    if (has_i) begin
      for (int c = t + 1; c <= t + 1 + ki; c++) begin
        s[c].stb = 1'b1; s[c].adr = ia; s[c].we = 1'b0;
      end
      tc = t + 1 + ki;
      av[tc] = (oi == 0 || oi == 2); ev[tc] = (oi == 1 || oi == 2); rd[tc] = rv_i;
      s[tc+1].iack = 1'b1; s[tc+1].berr = (oi != 0);
      ni = (oi == 0) ? rv_i : 16'hFFFF;
    end
    for (int c = 0; c <= len; c++) begin
      if (s[c].dack) cur_d = nd;
      if (s[c].iack) cur_i = ni;
      s[c].ddat = cur_d; s[c].idat = cur_i;
    end
    for (int c = 0; c <= len; c++) begin
      ibus_re = has_i; ibus_adr = ia;
      dbus_re = has_d & ~d_we; dbus_we = has_d & d_we;
      dbus_adr = da; dbus_s_dat_i = wd;
      wb_ack = av[c]; wb_err = ev[c]; wb_m_dat_i = rd[c];
      e_cur = s[c]; cur_c = c; exp_valid = 1'b1;
      @(posedge clk); #1;
    end
    exp_valid = 1'b0;
  endtask

  initial begin
    bit hi, hd, we;
    int kd, ki, od, oi, sel;
    int hang_bad;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_stb", 32'(wb_stb), 0);
    chk("rst_wb_cyc", 32'(wb_cyc), 0);
    chk("rst_wb_we", 32'(wb_we), 0);
    chk("rst_acks", {29'd0, ibus_ack, dbus_ack, bus_err}, 0);
    chk("rst_wb_adr", 32'(wb_adr), 0);
    chk("rst_wb_m_dat_o", 32'(wb_m_dat_o), 0);
    chk("rst_ibus_dat", 32'(ibus_dat), 0);
    chk("rst_dbus_dat", 32'(dbus_s_dat_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    clr_mon();
    run_instr(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000);
    chk("pin_rd_data", 32'(dbus_s_dat_o), 32'h0000BEEF);
    chk("pin_rd_ack_cyc", d_ack_at, 2);

    clr_mon();
    run_instr(1, 1, 1, 0, 0, 0, 0, 16'h0100, 16'h2000, 16'h1234, 16'h0000, 16'h5A5A);
    chk("pin_comb_first_adr", 32'(first_adr), 32'h00002000);
    chk("pin_comb_first_we", 32'(first_we), 1);
    chk("pin_comb_dack_cyc", d_ack_at, 2);
    chk("pin_comb_iack_cyc", i_ack_at, 4);
    chk("pin_comb_stall_cyc", stall_cnt, 4);

    clr_mon();
    run_instr(1, 0, 0, 0, 3, 0, 0, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h7777);
    chk("pin_ws_iack_cyc", i_ack_at, 5);
    chk("pin_ws_stb_cnt", stb_cnt, 4);

    clr_mon();
    run_instr(0, 1, 0, 1, 0, 2, 0, 16'h0000, 16'h0044, 16'h0000, 16'h1111, 16'h0000);
    chk("pin_err_data", 32'(dbus_s_dat_o), 32'h0000FFFF);
    chk("pin_err_berr_cnt", berr_cnt, 1);

    for (int n = 0; n < 250; n++) begin
      hi = 1'($urandom_range(0, 1));
      hd = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      kd = $urandom_range(0, 3);
      ki = $urandom_range(0, 3);
      sel = $urandom_range(0, 7);
      od = (sel < 5) ? 0 : (sel < 6) ? 1 : 2;
      sel = $urandom_range(0, 7);
      oi = (sel < 5) ? 0 : (sel < 6) ? 1 : 2;
`ifdef WB_J1_TIMEOUT_EN
      if ($urandom_range(0, 9) == 0) begin od = 3; kd = TO; end
      if ($urandom_range(0, 9) == 0) begin oi = 3; ki = TO; end
`endif
      run_instr(hi, hd, we, kd, ki, od, oi, 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom));
    end

    // Asynchronous reset in the middle of a wait-stated data cycle.
    ibus_re = 1'b0; dbus_we = 1'b0; dbus_re = 1'b1; dbus_adr = 16'h0300;
    wb_ack = 1'b0; wb_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_pre_stb", 32'(wb_stb), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_stb", 32'(wb_stb), 0);
    chk("rst_mid_cyc", 32'(wb_cyc), 0);
    chk("rst_mid_acks", {29'd0, ibus_ack, dbus_ack, bus_err}, 0);
    dbus_re = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; cur_i = '0; cur_d = '0;
    clr_mon();
    run_instr(1, 0, 0, 0, 1, 0, 0, 16'h0500, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE);
    chk("pin_post_rst_idat", 32'(ibus_dat), 32'h0000CAFE);
    chk("pin_post_rst_iack_cyc", i_ack_at, 3);

`ifdef WB_J1_TIMEOUT_EN
    clr_mon();
    run_instr(0, 1, 0, TO, 0, 3, 0, 16'h0000, 16'h0600, 16'h0000, 16'h0000, 16'h0000);
    chk("pin_to_data", 32'(dbus_s_dat_o), 32'h0000FFFF);
    chk("pin_to_berr_cnt", berr_cnt, 1);
`else
    ibus_re = 1'b1; ibus_adr = 16'h0600; wb_ack = 1'b0; wb_err = 1'b0;
    hang_bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (!stall || !wb_stb || ibus_ack || bus_err) hang_bad++;
    end
    chk("hang_no_timeout", hang_bad, 0);
    ibus_re = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; cur_i = '0; cur_d = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
